// File: rtl/bcd_display_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scan_if
//  Description : Bus bundle between a BCD source and the scanned
//                seven-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_scan_if #(
  parameter int DIGITS = 6
);
  logic [DIGITS*4-1:0] bcd;
  logic                blank_lz;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  // Source side: supplies the value, observes the display drive.
  modport master (
    output bcd, blank_lz,
    input  seg, an, frame
  );

  // Display driver side.
  modport slave (
    input  bcd, blank_lz,
    output seg, an, frame
  );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scan
//  Description : Time-multiplexed seven-segment driver. Scans a packed BCD
//                vector one digit per slot with a dark gap at the start of
//                each slot, optional leading-zero blanking, and a once-per-
//                frame snapshot so a changing count never shows torn.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scan #(
  parameter int DIGITS = 6,
  parameter int DIV    = 1000,
  parameter int GAP    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_display_scan_if.slave  bus
);

  localparam int PCW  = (DIV > 1)    ? $clog2(DIV)    : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCW-1:0]    PC_LAST  = PCW'(DIV - 1);
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  // Scan state and snapshot
  logic [PCW-1:0]      pc;
  logic [IDXW-1:0]     idx;
  logic [DIGITS*4-1:0] snap;
  logic                lz;

  // Registered outputs
  logic [6:0]          seg_reg;
  logic [DIGITS-1:0]   an_reg;
  logic                frame_reg;

  // Decode helpers
  logic                pc_wrap;
  logic                frame_end;
  logic                in_gap;
  logic [DIGITS-1:0]   dig_zero;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS*4-1:0] snap_shift;
  logic [DIGITS-1:0]   blank_shift;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic [6:0]          enc;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  assign pc_wrap   = (pc == PC_LAST);
  assign frame_end = pc_wrap && (idx == IDX_LAST);

  // A zero-width gap means the slot is lit from its first cycle.
  if (GAP == 0) begin : g_no_gap
    assign in_gap = 1'b0;
  end else begin : g_gap
    localparam logic [PCW-1:0] GAP_V = PCW'(GAP);
    assign in_gap = (pc < GAP_V);
  end

  // Per-digit zero flags of the snapshot.
  for (genvar i = 0; i < DIGITS; i++) begin : g_zero
    assign dig_zero[i] = (snap[4*i +: 4] == 4'd0);
  end

  // Digit i is blanked when it and every more significant digit are zero;
  // digit 0 always shows so a zero value reads "0".
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign blank[i] = lz && (&dig_zero[DIGITS-1:i]);
    end
  end

  assign snap_shift  = snap >> {idx, 2'b00};
  assign cur_nib     = snap_shift[3:0];
  assign blank_shift = blank >> idx;
  assign cur_blank   = blank_shift[0];

  // Segment encoding, gfedcba active-high; non-decimal nibbles show a dash.
  always_comb begin
    enc = 7'h40;
    case (cur_nib)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  end

  // Next output drive: dark during the gap or for a blanked digit.
  always_comb begin
    seg_next = 7'h00;
    an_next  = '0;
    if (!in_gap && !cur_blank) begin
      seg_next = enc;
      an_next  = AN_ONE << idx;
    end
  end

  // Prescaler and digit index; the index steps on each prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else begin
      pc <= pc_wrap ? '0 : pc + PCW'(1);
      if (pc_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
      end
    end
  end

  // Frame snapshot of the value and blanking mode on the last scan cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      lz   <= 1'b0;
    end else if (frame_end) begin
      snap <= bus.bcd;
      lz   <= bus.blank_lz;
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg   <= 7'h00;
      an_reg    <= '0;
      frame_reg <= 1'b0;
    end else begin
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      frame_reg <= frame_end;
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.an    = an_reg;
  assign bus.frame = frame_reg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_scan
//  Description : Scoreboard bench for bcd_display_scan with a behavioural
//                frame/slot model and randomized BCD values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scan;

  localparam int DIGITS = 6;
  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int FR     = DIGITS * DIV;

  typedef struct {
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              frame;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_display_scan_if #(.DIGITS(DIGITS)) bus ();

  bcd_display_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .GAP    (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  exp_t                q[$];
  int                  e;
  logic [DIGITS*4-1:0] msnap;
  logic                mlz;
  int                  fcnt = 0;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display expected after state cycle n, from the slot/frame arithmetic.
  function automatic exp_t model(input int n, input logic [DIGITS*4-1:0] s, input logic l);
    exp_t r;
    int   dig [DIGITS];
    int   msd = 0;
    int   slot_digit = (n / DIV) % DIGITS;
    int   phase = n % DIV;
    for (int i = 0; i < DIGITS; i++) begin
      dig[i] = int'(s[4*i +: 4]);
      if (dig[i] != 0) msd = i;
    end
    r.frame = ((n % FR) == FR - 1);
    if (phase < GAP || (l && slot_digit > msd)) begin
      r.seg = 7'h00;
      r.an  = '0;
    end else begin
      r.an  = DIGITS'(1 << slot_digit);
      r.seg = (dig[slot_digit] > 9) ? 7'h40 : seg_tab[dig[slot_digit]];
    end
    return r;
  endfunction

  // One state cycle: apply inputs and queue the response it must produce.
  task automatic cycle(input logic [DIGITS*4-1:0] b, input logic l);
    exp_t x;
    @(negedge clk);
    bus.bcd      = b;
    bus.blank_lz = l;
    x = model(e, msnap, mlz);
    q.push_back(x);
    if ((e % FR) == FR - 1) begin
      msnap = b;
      mlz   = l;
    end
    e++;
  endtask

  task automatic hold(input logic [DIGITS*4-1:0] b, input logic l, input int n);
    for (int i = 0; i < n; i++) cycle(b, l);
  endtask

  function automatic logic [DIGITS*4-1:0] rand_bcd();
    logic [DIGITS*4-1:0] v = '0;
    int len = $urandom_range(0, DIGITS);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic random_run(input int n);
    logic [DIGITS*4-1:0] b = rand_bcd();
    logic                l = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = rand_bcd();
        l = 1'($urandom_range(0, 1));
      end
      cycle(b, l);
    end
  endtask

  // Monitor: pops the expected response for every output cycle.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (!rst_n) begin
      fcnt = 0;
    end else begin
      if (q.size() > 0) begin
        x = q.pop_front();
        check("seg",   32'(bus.seg),   32'(x.seg));
        check("an",    32'(bus.an),    32'(x.an));
        check("frame", 32'(bus.frame), 32'(x.frame));
      end
      check("an_onehot0", 32'($onehot0(bus.an)), 32'd1);
      if (bus.an == '0) check("seg_dark", 32'(bus.seg), 32'd0);
      fcnt++;
      if (bus.frame) begin
        check("frame_period", 32'(fcnt), 32'(FR));
        fcnt = 0;
      end
    end
  end

  initial begin
    bus.bcd      = '0;
    bus.blank_lz = 1'b0;
    e     = 0;
    msnap = '0;
    mlz   = 1'b0;

    // Outputs held dark while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg",   32'(bus.seg),   32'd0);
    check("rst_an",    32'(bus.an),    32'd0);
    check("rst_frame", 32'(bus.frame), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First frame shows the reset snapshot (zero) on every digit.
    for (int i = 0; i < FR; i++) cycle(rand_bcd(), 1'b0);

    // Leading-zero blanking.
    hold(24'h000123, 1'b1, 2 * FR);
    hold(24'h000000, 1'b1, 2 * FR);

    // Tearing: value changes mid-frame, takes effect next frame only.
    while ((e % FR) != 0) cycle(24'h000999, 1'b1);
    hold(24'h000999, 1'b1, FR);
    hold(24'h000999, 1'b1, FR / 2);
    hold(24'h001000, 1'b1, FR - FR / 2);
    hold(24'h001000, 1'b1, 2 * FR);

    // Non-decimal nibble shows a dash.
    hold(24'h00000A, 1'b0, 2 * FR);

    random_run(20 * FR);

    // Asynchronous reset while digit 3 is lit.
    while ((e % FR) != 3 * DIV + 2) cycle(24'h123456, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_an", 32'(bus.an), 32'h08);
    rst_n = 1'b0;
    #1;
    check("async_rst_seg",   32'(bus.seg),   32'd0);
    check("async_rst_an",    32'(bus.an),    32'd0);
    check("async_rst_frame", 32'(bus.frame), 32'd0);
    q.delete();
    e     = 0;
    msnap = '0;
    mlz   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    random_run(4 * FR);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
